// File: rtl/reg_file_param.sv
// Parameterised byte-strobed register file with registered write-first reads
// and a one-entry-per-cycle clear sweep.
module reg_file_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    write_en,
    input  logic [ADDR_WIDTH-1:0]   write_addr,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] write_strb,
    input  logic                    read_en,
    input  logic [ADDR_WIDTH-1:0]   read_addr,
    input  logic                    clear_req,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    read_valid,
    output logic                    busy,
    output logic                    addr_err
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [IW-1:0]         r_cnt;

    logic                  w_idle;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_wr_in;
    logic                  w_rd_in;
    logic                  w_hit;
    logic [IW-1:0]         w_widx;
    logic [IW-1:0]         w_ridx;
    logic [DATA_WIDTH-1:0] w_wr_word;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign w_idle   = (r_state == S_IDLE);
    assign w_wr_acc = w_idle & write_en & ~clear_req;
    assign w_rd_acc = w_idle & read_en & ~clear_req;
    assign w_wr_in  = ({1'b0, write_addr} < LIM);
    assign w_rd_in  = ({1'b0, read_addr} < LIM);
    assign w_widx   = write_addr[IW-1:0];
    assign w_ridx   = read_addr[IW-1:0];
    assign w_hit    = w_wr_acc & w_wr_in & (write_addr == read_addr);

    always_comb begin
        w_wr_word = r_mem[w_widx];
        for (int b = 0; b < NB; b++) begin
            if (write_strb[b]) begin
                w_wr_word[8*b +: 8] = write_data[8*b +: 8];
            end
        end
    end

    // Same-address write in this cycle forwards its merged word (write-first)
    always_comb begin
        w_rd_word = '0;
        if (w_rd_in) begin
            w_rd_word = w_hit ? w_wr_word : r_mem[w_ridx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (clear_req) begin
                    w_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                busy = 1'b1;
                if (r_cnt == LAST) begin
                    w_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_cnt      <= '0;
            read_data  <= '0;
            read_valid <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            read_valid <= w_rd_acc;
            addr_err   <= (w_rd_acc & ~w_rd_in) | (w_wr_acc & ~w_wr_in);
            if (w_rd_acc) begin
                read_data <= w_rd_word;
            end
            if (w_wr_acc && w_wr_in) begin
                r_mem[w_widx] <= w_wr_word;
            end
            if (busy) begin
                r_mem[r_cnt] <= '0;
                r_cnt        <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_reg_file_param.sv
// Randomised bench for reg_file_param against an array-based reference model;
// a second DEPTH=12 instance covers out-of-range addressing.
module tb_reg_file_param;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, we, re, clr;
    logic [3:0]  wa, ra, ws;
    logic [31:0] wd, rd;
    logic        rv, bz, ae;

    logic        rst2, we2, re2, clr2;
    logic [3:0]  wa2, ra2, ws2;
    logic [31:0] wd2, rd2;
    logic        rv2, bz2, ae2;

    reg_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16)) u_dut (
        .clk(clk), .rst(rst), .write_en(we), .write_addr(wa),
        .write_data(wd), .write_strb(ws), .read_en(re), .read_addr(ra),
        .clear_req(clr), .read_data(rd), .read_valid(rv), .busy(bz),
        .addr_err(ae)
    );

    reg_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(12)) u_dut12 (
        .clk(clk), .rst(rst2), .write_en(we2), .write_addr(wa2),
        .write_data(wd2), .write_strb(ws2), .read_en(re2), .read_addr(ra2),
        .clear_req(clr2), .read_data(rd2), .read_valid(rv2), .busy(bz2),
        .addr_err(ae2)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] m [16];
    logic [31:0] exp_rd;
    logic        exp_v;

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_zero;
        for (int i = 0; i < 16; i++) m[i] = 32'h0;
    endtask

    task automatic op(input logic w, input logic [3:0] a_w,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic r, input logic [3:0] a_r);
        we = w; wa = a_w; wd = d; ws = s;
        re = r; ra = a_r; clr = 1'b0;
        if (w) m[a_w] = merge(m[a_w], d, s);
        exp_v = r;
        if (r) exp_rd = m[a_r];
        tick;
        we = 1'b0; re = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; we = 1'b1; wa = 4'd3; wd = $urandom; ws = 4'hF;
        re = 1'b1; ra = 4'd3; clr = 1'b1;
        tick; tick;
        n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_rd: got %h want 0", rd); end
        n_chk++; if (rv !== 1'b0) begin n_fail++; $display("FAIL reset_rv: got %b want 0", rv); end
        n_chk++; if (bz !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bz); end
        n_chk++; if (ae !== 1'b0) begin n_fail++; $display("FAIL reset_aerr: got %b want 0", ae); end
        rst = 1'b0; we = 1'b0; re = 1'b0; clr = 1'b0;
        model_zero();
        exp_rd = 32'h0;
        op(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3);
        n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rd_after_reset: got %h want 0", rd); end
        n_chk++; if (rv !== 1'b1) begin n_fail++; $display("FAIL rv_after_reset: got %b want 1", rv); end
    endtask

    task automatic test_strobe;
        op(1'b1, 4'd0, 32'h43211234, 4'hF, 1'b0, 4'd0);
        n_chk++; if (rv !== 1'b0) begin n_fail++; $display("FAIL strb_novalid: got %b want 0", rv); end
        n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL strb_hold: got %h want 0", rd); end
        op(1'b1, 4'd0, 32'hFFFFFFFF, 4'h2, 1'b0, 4'd0);
        op(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd0);
        n_chk++; if (rd !== 32'h4321FF34) begin n_fail++; $display("FAIL strb_merge: got %h want 4321ff34", rd); end
        n_chk++; if (rv !== 1'b1) begin n_fail++; $display("FAIL strb_rv: got %b want 1", rv); end
    endtask

    task automatic test_write_first;
        op(1'b1, 4'd5, 32'h8BAA2468, 4'hF, 1'b1, 4'd5);
        n_chk++; if (rd !== 32'h8BAA2468) begin n_fail++; $display("FAIL wf_full: got %h want 8baa2468", rd); end
        n_chk++; if (rv !== 1'b1) begin n_fail++; $display("FAIL wf_rv: got %b want 1", rv); end
        op(1'b1, 4'd5, 32'h11223344, 4'b0101, 1'b1, 4'd5);
        n_chk++; if (rd !== 32'h8B222444) begin n_fail++; $display("FAIL wf_part: got %h want 8b222444", rd); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++) begin
            op(1'($urandom), 4'($urandom), $urandom, 4'($urandom),
               1'($urandom), 4'($urandom));
            n_chk++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rnd_rd[%0d]: got %h want %h", i, rd, exp_rd); end
            n_chk++; if (rv !== exp_v) begin n_fail++; $display("FAIL rnd_rv[%0d]: got %b want %b", i, rv, exp_v); end
            n_chk++; if (ae !== 1'b0) begin n_fail++; $display("FAIL rnd_aerr[%0d]: got %b want 0", i, ae); end
        end
    endtask

    task automatic fill;
        for (int a = 0; a < 16; a++) begin
            op(1'b1, 4'(a), $urandom | 32'h1, 4'hF, 1'b0, 4'd0);
        end
    endtask

    task automatic test_clear;
        fill();
        we = 1'b1; wa = 4'd7; wd = 32'hCAFEF00D; ws = 4'hF;
        re = 1'b1; ra = 4'd7; clr = 1'b1;
        tick;
        model_zero();
        exp_v = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_chk++; if (bz !== 1'b1) begin n_fail++; $display("FAIL clr_busy[%0d]: got %b want 1", i, bz); end
            n_chk++; if (rv !== 1'b0 || ae !== 1'b0) begin n_fail++; $display("FAIL clr_quiet[%0d]: got rv=%b ae=%b want 0", i, rv, ae); end
            n_chk++; if (rd !== exp_rd) begin n_fail++; $display("FAIL clr_hold[%0d]: got %h want %h", i, rd, exp_rd); end
            if (i == 2) begin
                we = 1'b1; wa = 4'd2; wd = 32'h12345678; ws = 4'hF;
                re = 1'b1; ra = 4'd2; clr = 1'b1;
            end else begin
                we = 1'($urandom); wa = 4'($urandom); wd = $urandom;
                ws = 4'hF; re = 1'($urandom); ra = 4'($urandom);
                clr = 1'($urandom);
            end
            tick;
        end
        we = 1'b0; re = 1'b0; clr = 1'b0;
        n_chk++; if (bz !== 1'b0) begin n_fail++; $display("FAIL clr_done: got %b want 0", bz); end
        n_chk++; if (rv !== 1'b0) begin n_fail++; $display("FAIL clr_last_rv: got %b want 0", rv); end
        for (int a = 0; a < 16; a++) begin
            op(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(a));
            n_chk++; if (rd !== 32'h0 || rv !== 1'b1) begin n_fail++; $display("FAIL clr_read[%0d]: got %h/%b want 0/1", a, rd, rv); end
        end
    endtask

    task automatic test_rst_in_clear;
        fill();
        clr = 1'b1;
        tick;
        clr = 1'b0;
        repeat (4) tick;
        n_chk++; if (bz !== 1'b1) begin n_fail++; $display("FAIL rc_busy5: got %b want 1", bz); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        model_zero();
        exp_rd = 32'h0;
        n_chk++; if (bz !== 1'b0) begin n_fail++; $display("FAIL rc_busy: got %b want 0", bz); end
        n_chk++; if (rd !== 32'h0 || rv !== 1'b0) begin n_fail++; $display("FAIL rc_out: got %h/%b want 0/0", rd, rv); end
        op(1'b1, 4'd9, 32'hA5A55A5A, 4'hF, 1'b0, 4'd0);
        op(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd9);
        n_chk++; if (rd !== 32'hA5A55A5A) begin n_fail++; $display("FAIL rc_wr9: got %h want a5a55a5a", rd); end
        for (int a = 10; a < 16; a++) begin
            op(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(a));
            n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rc_read[%0d]: got %h want 0", a, rd); end
        end
        n_chk++; if (bz !== 1'b0) begin n_fail++; $display("FAIL rc_idle: got %b want 0", bz); end
    endtask

    task automatic test_depth12;
        int cyc;
        rst2 = 1'b1;
        tick;
        rst2 = 1'b0;
        we2 = 1'b1; wa2 = 4'd13; wd2 = 32'hDEADBEEF; ws2 = 4'hF;
        tick;
        we2 = 1'b0;
        n_chk++; if (ae2 !== 1'b1 || rv2 !== 1'b0) begin n_fail++; $display("FAIL d12_wr_oor: got ae=%b rv=%b want 1/0", ae2, rv2); end
        tick;
        n_chk++; if (ae2 !== 1'b0) begin n_fail++; $display("FAIL d12_pulse: got %b want 0", ae2); end
        we2 = 1'b1; wa2 = 4'd11; wd2 = 32'h0BADCAFE;
        tick;
        we2 = 1'b0;
        re2 = 1'b1; ra2 = 4'd13;
        tick;
        re2 = 1'b0;
        n_chk++; if (rd2 !== 32'h0 || rv2 !== 1'b1 || ae2 !== 1'b1) begin n_fail++; $display("FAIL d12_rd_oor: got %h/%b/%b want 0/1/1", rd2, rv2, ae2); end
        for (int a = 0; a < 12; a++) begin
            re2 = 1'b1; ra2 = 4'(a);
            tick;
            n_chk++; if (rd2 !== ((a == 11) ? 32'h0BADCAFE : 32'h0) || ae2 !== 1'b0) begin n_fail++; $display("FAIL d12_read[%0d]: got %h ae=%b", a, rd2, ae2); end
        end
        we2 = 1'b1; wa2 = 4'd14; re2 = 1'b1; ra2 = 4'd15;
        tick;
        n_chk++; if (ae2 !== 1'b1 || rv2 !== 1'b1 || rd2 !== 32'h0) begin n_fail++; $display("FAIL d12_both: got ae=%b rv=%b rd=%h want 1/1/0", ae2, rv2, rd2); end
        we2 = 1'b0; ra2 = 4'd12;
        tick;
        re2 = 1'b0;
        n_chk++; if (ae2 !== 1'b1 || rd2 !== 32'h0) begin n_fail++; $display("FAIL d12_edge: got ae=%b rd=%h want 1/0", ae2, rd2); end
        clr2 = 1'b1;
        tick;
        clr2 = 1'b0;
        cyc = 0;
        while (bz2 === 1'b1 && cyc < 40) begin
            cyc++;
            tick;
        end
        n_chk++; if (cyc !== 12) begin n_fail++; $display("FAIL d12_clr_len: got %0d want 12", cyc); end
        re2 = 1'b1; ra2 = 4'd11;
        tick;
        re2 = 1'b0;
        n_chk++; if (rd2 !== 32'h0 || rv2 !== 1'b1) begin n_fail++; $display("FAIL d12_clr_rd: got %h/%b want 0/1", rd2, rv2); end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; clr = 1'b0;
        wa = '0; ra = '0; ws = '0; wd = '0;
        rst2 = 1'b1; we2 = 1'b0; re2 = 1'b0; clr2 = 1'b0;
        wa2 = '0; ra2 = '0; ws2 = '0; wd2 = '0;
        exp_rd = 32'h0; exp_v = 1'b0;
        model_zero();
        test_reset();
        test_strobe();
        test_write_first();
        test_random();
        test_clear();
        test_rst_in_clear();
        test_depth12();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
